// File: rtl/if_stage_fb_pkg.sv
// Shared widths and bundle layouts for the if_stage_fb fetch stage and its FIFO.
// Holds the branch bus and the fetch-to-decode entry layouts, plus the inst_sram word-size code.
`timescale 1ns/1ps
package if_stage_fb_pkg;

    localparam int         BR_BUS_WD       = 33;
    localparam int         FS_TO_DS_BUS_WD = 64;
    localparam logic [1:0] INST_SIZE_WORD  = 2'd2;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_entry_t;

endpackage

// File: rtl/if_stage_fb_if.sv
// SRAM-like instruction port: req/addr_ok on the request side, data_ok/rdata on the response side.
`timescale 1ns/1ps
interface if_stage_fb_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/if_stage_fb_fifo.sv
// Parametrised synchronous FIFO with flush and occupancy count; push and pop may coincide when full.
`timescale 1ns/1ps
module if_stage_fb_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap so non-power-of-two depths work for the in-flight PC queue.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_stage_fb.sv
// LoongArch32 IF stage: pipelined inst_sram fetch with an in-flight PC queue and a fetch buffer.
// Define FS_BYPASS_EN to forward a response straight to ID when the buffer is empty.
`timescale 1ns/1ps
module if_stage_fb
    import if_stage_fb_pkg::*;
#(
    parameter int          FB_DEPTH  = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    if_stage_fb_if.master              inst_sram
);

    localparam int CW = $clog2(FB_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int SW = CW + 1;

    br_bus_t       br;
    logic [31:0]   fetch_pc;
    logic [OW-1:0] outst;
    logic [OW-1:0] discard;
    logic [CW-1:0] fb_count;
    logic [31:0]   pcq_head;
    logic [63:0]   fb_head;
    fs_entry_t     fb_wdata;
    logic [SW-1:0] reserved;
    logic          accept;
    logic          rsp;
    logic          rsp_live;
    logic          fb_push;
    logic          fb_pop;
    logic          bypass_take;

    assign br  = br_bus;
    assign rsp = inst_sram.data_ok;

    // Buffered words plus live in-flight requests; a new request needs a free slot beyond these.
    assign reserved = SW'(fb_count) + SW'(outst) - SW'(discard);

    assign inst_sram.req   = resetn && !br.taken && (outst < OW'(MAX_OUTST)) && (reserved < SW'(FB_DEPTH));
    assign inst_sram.addr  = fetch_pc;
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.size  = INST_SIZE_WORD;
    assign inst_sram.wstrb = 4'h0;
    assign inst_sram.wdata = 32'h0;

    assign accept   = inst_sram.req && inst_sram.addr_ok;
    assign rsp_live = rsp && (discard == '0) && !br.taken;
    assign fb_wdata = '{inst: inst_sram.rdata, pc: pcq_head};

`ifdef FS_BYPASS_EN
    logic bypass;
    assign bypass         = (fb_count == '0) && rsp_live;
    assign bypass_take    = bypass && ds_allowin;
    assign fs_to_ds_valid = ((fb_count != '0) && !br.taken) || bypass;
    assign fs_to_ds_bus   = !fs_to_ds_valid ? '0 : (bypass ? fb_wdata : fb_head);
`else
    assign bypass_take    = 1'b0;
    assign fs_to_ds_valid = (fb_count != '0) && !br.taken;
    assign fs_to_ds_bus   = fs_to_ds_valid ? fb_head : '0;
`endif

    assign fb_push = rsp_live && !bypass_take;
    assign fb_pop  = fs_to_ds_valid && ds_allowin && (fb_count != '0);

    // A branch marks every request still in flight after this cycle as stale.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (br.taken) begin
            fetch_pc <= br.target;
            discard  <= outst - OW'(rsp);
        end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (rsp && (discard != '0)) discard <= discard - OW'(1);
        end
    end

    if_stage_fb_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) pc_q (
        .clk    (clk),
        .resetn (resetn),
        .flush  (1'b0),
        .push   (accept),
        .wdata  (fetch_pc),
        .pop    (rsp),
        .rdata  (pcq_head),
        .count  (outst)
    );

    if_stage_fb_fifo #(.WIDTH(64), .DEPTH(FB_DEPTH)) fetch_buf (
        .clk    (clk),
        .resetn (resetn),
        .flush  (br.taken),
        .push   (fb_push),
        .wdata  (fb_wdata),
        .pop    (fb_pop),
        .rdata  (fb_head),
        .count  (fb_count)
    );

    no_orphan_response: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_sram.data_ok && (outst == '0)));

endmodule

// File: tb/tb_if_stage_fb.sv
// Self-checking bench for if_stage_fb: variable-latency memory model plus an in-order scoreboard.
`timescale 1ns/1ps
module tb_if_stage_fb;
    import if_stage_fb_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
`ifdef FS_BYPASS_EN
    localparam int FIRST_VALID = 1;
    localparam int STEADY_CNT  = 0;
`else
    localparam int FIRST_VALID = 2;
    localparam int STEADY_CNT  = 1;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          ready;
        bit          live;
    } mem_req_t;

    typedef struct {
        int          ncyc;
        logic [15:0] allow_pat;
        int          lat;
        int          exp_req;
        int          exp_cnt;
    } row_t;

    logic                       clk;
    logic                       resetn;
    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

    if_stage_fb_if inst_sram ();

    mem_req_t    mem_q[$];
    logic [63:0] sb_q[$];
    logic [31:0] exp_fetch;
    int          cyc;
    int          lat;
    int          n_checks;
    int          n_fail;

    if_stage_fb #(.FB_DEPTH(4), .MAX_OUTST(2), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram      (inst_sram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5a5a, pc[31:16] ^ 16'h0f0f};
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: drive inputs at negedge, sample #1 later, then update the memory model and scoreboard.
    task automatic applyStimulus(input logic allow, input logic br, input logic [31:0] tgt);
        logic     rsp;
        mem_req_t e;
        @(negedge clk);
        ds_allowin        = allow;
        br_bus            = {br, tgt};
        rsp               = (mem_q.size() != 0) && (mem_q[0].ready <= cyc);
        inst_sram.addr_ok = 1'b1;
        inst_sram.data_ok = rsp;
        inst_sram.rdata   = rsp ? inst_of(mem_q[0].addr) : 32'hdeadbeef;
        #1;
        if (br) checkOutput("req_in_branch", 96'(inst_sram.req), 96'(0));
        if (rsp) begin
            e = mem_q.pop_front();
            if (e.live && !br) sb_q.push_back({inst_of(e.pc), e.pc});
        end
        if (inst_sram.req && inst_sram.addr_ok) begin
            checkOutput("req_addr", 96'(inst_sram.addr), 96'(exp_fetch));
            mem_q.push_back('{addr: inst_sram.addr, pc: exp_fetch, ready: cyc + lat, live: 1'b1});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (fs_to_ds_valid && allow) begin
            if (sb_q.size() == 0) checkOutput("spurious_valid", 96'(fs_to_ds_valid), 96'(0));
            else                  checkOutput("delivered", 96'(fs_to_ds_bus), 96'(sb_q.pop_front()));
        end
        if (br) begin
            checkOutput("valid_in_branch", 96'(fs_to_ds_valid), 96'(0));
            sb_q.delete();
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            exp_fetch = tgt;
        end
        cyc++;
    endtask

    initial begin
        row_t rows [6];
        bit   found;
        int   exp_disc;

        rows[0] = '{12, 16'hFFFF, 1, 1, STEADY_CNT};
        rows[1] = '{10, 16'h0000, 1, 0, 4};
        rows[2] = '{12, 16'hFFFF, 1, 1, 2};
        rows[3] = '{16, 16'hAAAA, 2, -1, -1};
        rows[4] = '{16, 16'hFFFF, 3, -1, -1};
        rows[5] = '{14, 16'h0000, 3, 0, 4};

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat      = 1;
        exp_fetch = RESET_PC;
        resetn = 1'b0;
        ds_allowin = 1'b1;
        br_bus = '0;
        inst_sram.addr_ok = 1'b0;
        inst_sram.data_ok = 1'b0;
        inst_sram.rdata   = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req", 96'(inst_sram.req), 96'(0));
        checkOutput("reset_valid", 96'(fs_to_ds_valid), 96'(0));
        checkOutput("reset_bus", 96'(fs_to_ds_bus), 96'(0));
        checkOutput("reset_fetch_pc", 96'(dut.fetch_pc), 96'(RESET_PC));
        @(negedge clk);
        resetn = 1'b1;

        // First fill with zero-wait memory.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (i == 0)
                checkOutput("first_req_addr", 96'({inst_sram.req, inst_sram.addr}), 96'({1'b1, RESET_PC}));
            if (i >= FIRST_VALID && i < FIRST_VALID + 3)
                checkOutput("first_fill", 96'({fs_to_ds_valid, fs_to_ds_bus}),
                            96'({1'b1, inst_of(RESET_PC + 32'(4 * (i - FIRST_VALID))),
                                 RESET_PC + 32'(4 * (i - FIRST_VALID))}));
        end

        for (int r = 0; r < 6; r++) begin
            lat = rows[r].lat;
            for (int i = 0; i < rows[r].ncyc; i++)
                applyStimulus(rows[r].allow_pat[i], 1'b0, 32'h0);
            @(posedge clk);
            #1;
            if (rows[r].exp_req >= 0) checkOutput("row_req", 96'(inst_sram.req), 96'(rows[r].exp_req));
            if (rows[r].exp_cnt >= 0) checkOutput("row_count", 96'(dut.fb_count), 96'(rows[r].exp_cnt));
        end

        // Branch with two requests outstanding and no response in the branch cycle.
        lat = 3;
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            if (mem_q.size() == 2 && mem_q[0].ready > cyc) found = 1'b1;
            else applyStimulus(1'b1, 1'b0, 32'h0);
        end
        checkOutput("branch1_setup", 96'(found), 96'(1));
        applyStimulus(1'b1, 1'b1, 32'h1c000100);
        @(posedge clk);
        #1;
        checkOutput("branch1_discard", 96'(dut.discard), 96'(2));
        checkOutput("branch1_fetch_pc", 96'(dut.fetch_pc), 96'(32'h1c000100));
        found = 1'b0;
        for (int w = 0; w < 30 && !found; w++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (fs_to_ds_valid) begin
                found = 1'b1;
                checkOutput("branch1_first_pc", 96'(fs_to_ds_bus[31:0]), 96'(32'h1c000100));
            end
        end
        checkOutput("branch1_delivery_seen", 96'(found), 96'(1));

        // Branch in the same cycle as a response, with a second request still in flight.
        lat = 2;
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            if (mem_q.size() == 2 && mem_q[0].ready <= cyc) found = 1'b1;
            else applyStimulus(1'b1, 1'b0, 32'h0);
        end
        checkOutput("branch2_setup", 96'(found), 96'(1));
        exp_disc = int'(mem_q.size()) - 1;
        applyStimulus(1'b1, 1'b1, 32'h1c000200);
        @(posedge clk);
        #1;
        checkOutput("branch2_discard", 96'(dut.discard), 96'(exp_disc));
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("branch2_next_req", 96'({inst_sram.req, inst_sram.addr}), 96'({1'b1, 32'h1c000200}));
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        // Asynchronous reset in the middle of a burst.
        lat = 1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        resetn = 1'b0;
        inst_sram.addr_ok = 1'b0;
        inst_sram.data_ok = 1'b0;
        #1;
        checkOutput("midreset_outputs", 96'({inst_sram.req, fs_to_ds_valid, fs_to_ds_bus}), 96'(0));
        mem_q.delete();
        sb_q.delete();
        exp_fetch = RESET_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("restart_addr", 96'({inst_sram.req, inst_sram.addr}), 96'({1'b1, RESET_PC}));
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage_fb.md
Name: if_stage_fb

Overview:
- Next-generation instruction-fetch stage for the LoongArch32 five-stage pipeline, placed between the pre-IF PC logic and ID (ds).
- Drives an SRAM-like instruction port with a req/addr_ok/data_ok handshake, so variable-latency responses are supported.
- Allows up to MAX_OUTST requests in flight and buffers returned {inst, pc} pairs in a FB_DEPTH-entry FIFO.
- Branches redirect fetch, flush the buffer and discard stale in-flight responses.

Parameters:
- FB_DEPTH, 4, fetch-buffer entries; power of two, >=2.
- MAX_OUTST, 2, maximum accepted-but-unanswered requests; 1..FB_DEPTH.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  single clock, all state on posedge.
- resetn  in  1  asynchronous active-low reset, synchronously deasserted externally.
- ds_allowin  in  1  ID can accept an instruction this cycle.
- br_bus  in  BR_BUS_WD(33)  {br_taken, br_target[31:0]}; br_taken is a one-cycle pulse.
- fs_to_ds_valid  out  1  head entry valid to ID.
- fs_to_ds_bus  out  FS_TO_DS_BUS_WD(64)  {inst[31:0], pc[31:0]}.
- inst_sram_req  out  1  request valid.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'd2 (word).
- inst_sram_wstrb  out  4  constant 4'h0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_addr_ok  in  1  request accepted this cycle when req=1.
- inst_sram_data_ok  in  1  oldest outstanding request returns data.
- inst_sram_rdata  in  32  instruction word, valid with data_ok.

Behaviour:
- Reset (resetn=0, asynchronous) clears state:
  - fetch_pc=RESET_PC; fb count, rd_ptr, wr_ptr=0; outst=0; discard=0.
  - Outputs: inst_sram_req=0, fs_to_ds_valid=0, fs_to_ds_bus=0 (buffer entries need not be cleared).
- If reset is asserted mid-transaction, all in-flight requests are forgotten; the memory side is reset by the same signal.
- Issue:
  - req = !br_taken && (outst < MAX_OUTST) && (count + outst - discard < FB_DEPTH).
  - Every returned live word therefore has a reserved slot, and overflow cannot occur.
  - addr = fetch_pc.
- Accept (req && addr_ok):
  - Push fetch_pc into the in-flight PC queue (MAX_OUTST deep).
  - outst++, fetch_pc += 4 (32-bit wrap, no trap).
- Response (data_ok):
  - Pop the PC queue; outst--.
  - If discard>0: drop the word, discard--.
  - Else: push {rdata, pc} into the fetch buffer.
- Accept and response in the same cycle: outst is unchanged, and the queue pushes and pops together.
- Output:
  - fs_to_ds_valid = (count!=0) && !br_taken.
  - Pop when fs_to_ds_valid && ds_allowin.
  - Push and pop in the same cycle are legal, including when full.
- Branch (br_taken=1):
  - fetch_pc <= br_target; count <= 0 and pointers reset.
  - discard <= outst_next - (data_ok && discard==0 ? 0 : 0), i.e. every request still outstanding after this cycle's accept/response is marked stale.
  - The response word arriving in the branch cycle is dropped.
  - No request is issued in the branch cycle.
  - The first target request is issued next cycle.
- Latency:
  - addr_ok to data_ok is set by memory.
  - data_ok to fs_to_ds_valid is 1 cycle (registered buffer).
  - Steady state is 1 instr/cycle when memory returns 1 instr/cycle with MAX_OUTST>=2.
- Empty buffer: valid=0, no pop.
- Full buffer plus outstanding: req held low.
- discard never underflows; data_ok while outst==0 is illegal and flagged by an assertion.

Optional Feature:
- FS_BYPASS_EN defined:
  - When count==0, discard==0, data_ok=1 and !br_taken, {rdata, pc} is presented combinationally on fs_to_ds_bus with fs_to_ds_valid=1.
  - If ds_allowin=1, the word is consumed without being written to the buffer (0-cycle data_ok to valid).
  - Otherwise it is written to the buffer as normal.
- Undefined: all responses go through the buffer, giving 1-cycle latency and fully registered outputs.

Decomposition:
- BR_BUS_WD, FS_TO_DS_BUS_WD and the inst_sram size encodings stay in mycpu_head.v (shared header).
- One natural sub-module, if_fifo:
  - A parametrised sync FIFO (WIDTH, DEPTH), used twice: for the PC queue (WIDTH=32, DEPTH=MAX_OUTST) and the fetch buffer (WIDTH=64, DEPTH=FB_DEPTH).
  - It has a flush input and exposes count.

Test Plan:
- Reset release with a zero-wait memory (addr_ok=1, data_ok the next cycle), ds_allowin=1:
  - first req addr is 0x1c000000;
  - ID receives pcs 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles after the first fill.
- ds_allowin=0 for 10 cycles:
  - req stops after 4 words are buffered or reserved; count=4; no word is lost;
  - after release, pcs continue in order with no gap.
- Branch with 2 outstanding, br_target=0x1c000100:
  - the next 2 data_ok words are dropped;
  - the first instruction delivered has pc 0x1c000100.
- br_taken in the same cycle as data_ok and addr_ok:
  - that response is dropped and the accepted request is discarded;
  - the next req addr is the target.
- Assert resetn low mid-burst, then release:
  - outputs are 0 immediately;
  - fetch restarts at 0x1c000000 and no stale word appears.
- With FS_BYPASS_EN, an empty buffer and ds_allowin=1:
  - fs_to_ds_valid rises in the data_ok cycle, carrying rdata.
